// File: rtl/key_sel3_pkg.sv
// Shared widths and filter state encoding for the key_sel3 front end.
package key_sel3_pkg;

    localparam int SEL_W  = 3;
    localparam int CNT_W  = 20;
    localparam int AUTO_W = 25;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        DOWN       = 2'd2,
        REL_FILT   = 2'd3
    } filt_state_t;

endpackage

// File: rtl/key_filter.sv
// Debounce filter for one active-low button: 2-flop synchronizer, 4-state
// filter FSM with window counter, single press pulse per accepted press.
module key_filter
    import key_sel3_pkg::*;
#(
    parameter logic [CNT_W-1:0] CNT_MAX = 20'd999_999
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_n,
    output logic press
);

    logic            key_p0;
    logic            key_p1;
    filt_state_t     state;
    logic [CNT_W-1:0] cnt;

    // Stage p0/p1: synchronizer; filter FSM works on key_p1.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            key_p0 <= 1'b1;
            key_p1 <= 1'b1;
            state  <= IDLE;
            cnt    <= '0;
        end else begin
            key_p0 <= key_n;
            key_p1 <= key_p0;
            case (state)
                IDLE: begin
                    if (!key_p1) begin
                        state <= PRESS_FILT;
                        cnt   <= '0;
                    end
                end
                PRESS_FILT: begin
                    if (key_p1) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= DOWN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DOWN: begin
                    if (key_p1) begin
                        state <= REL_FILT;
                        cnt   <= '0;
                    end
                end
                REL_FILT: begin
                    if (!key_p1) begin
                        state <= DOWN;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Pulse is the last accepted filter cycle, decoded from registered state only.
    assign press = (state == PRESS_FILT) && !key_p1 && (cnt == CNT_MAX);

endmodule

// File: rtl/key_sel3.sv
// Debounced up/down buttons driving a 3-bit select index for the 3-to-8 decoder.
// Optional free-running auto-advance built when KEY_SEL3_AUTO_RUN_EN is defined.
module key_sel3
    import key_sel3_pkg::*;
#(
    parameter logic [CNT_W-1:0] CNT_MAX = 20'd999_999
`ifdef KEY_SEL3_AUTO_RUN_EN
    , parameter logic [AUTO_W-1:0] AUTO_MAX = 25'd24_999_999
`endif
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_up,
    input  logic key_dn,
    output logic in1,
    output logic in2,
    output logic in3,
    output logic sel_vld
);

    logic             up_pulse;
    logic             dn_pulse;
    logic [SEL_W-1:0] sel;

    key_filter #(.CNT_MAX(CNT_MAX)) u_up (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .key_n   (key_up),
        .press   (up_pulse)
    );

    key_filter #(.CNT_MAX(CNT_MAX)) u_dn (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .key_n   (key_dn),
        .press   (dn_pulse)
    );

`ifdef KEY_SEL3_AUTO_RUN_EN
    logic [AUTO_W-1:0] auto_cnt;
`endif

    // Index register: a lone key pulse steps the index; coincident pulses cancel.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sel     <= '0;
            sel_vld <= 1'b0;
`ifdef KEY_SEL3_AUTO_RUN_EN
            auto_cnt <= '0;
`endif
        end else begin
            sel_vld <= 1'b0;
            if (up_pulse ^ dn_pulse) begin
                sel     <= up_pulse ? sel + SEL_W'(1) : sel - SEL_W'(1);
                sel_vld <= 1'b1;
            end
`ifdef KEY_SEL3_AUTO_RUN_EN
            // Any key activity restarts the auto period and wins over a tick.
            if (up_pulse || dn_pulse) begin
                auto_cnt <= '0;
            end else if (auto_cnt == AUTO_MAX) begin
                auto_cnt <= '0;
                sel      <= sel + SEL_W'(1);
                sel_vld  <= 1'b1;
            end else begin
                auto_cnt <= auto_cnt + 1'b1;
            end
`endif
        end
    end

    assign {in1, in2, in3} = sel;

endmodule

// File: tb/tb_key_sel3.sv
// Self-checking bench for key_sel3 with a short debounce window and auto period.
module tb_key_sel3;

    localparam logic [19:0] CNT_MAX  = 20'd4;
    localparam logic [24:0] AUTO_MAX = 25'd15;
    localparam int          WIN      = 6;   // consecutive synced samples needed
    localparam int          LAT      = 8;   // fall to visible sel_vld

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic key_up  = 1'b1;
    logic key_dn  = 1'b1;
    logic in1, in2, in3, sel_vld;

    int n_pass  = 0;
    int n_total = 0;

    always #5 sys_clk = ~sys_clk;

    key_sel3 #(
        .CNT_MAX (CNT_MAX)
`ifdef KEY_SEL3_AUTO_RUN_EN
        , .AUTO_MAX (AUTO_MAX)
`endif
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .key_up  (key_up),
        .key_dn  (key_dn),
        .in1     (in1),
        .in2     (in2),
        .in3     (in3),
        .sel_vld (sel_vld)
    );

    // Reference: a key is accepted once its synced level holds WIN samples in a row.
    logic [1:0] m_s1, m_s2, m_last, m_low;
    int         m_run [2];
    int         m_auto;
    logic [2:0] exp_sel;
    logic       exp_vld;

    always @(posedge sys_clk) begin
        logic [1:0] syn;
        logic [1:0] pulse;
        logic [2:0] s;
        logic       v;
        int         r;
        if (sys_rst) begin
            m_s1    <= 2'b11;
            m_s2    <= 2'b11;
            m_last  <= 2'b11;
            m_low   <= 2'b00;
            m_run[0] <= 0;
            m_run[1] <= 0;
            m_auto  <= 0;
            exp_sel <= 3'd0;
            exp_vld <= 1'b0;
        end else begin
            syn   = m_s2;
            pulse = 2'b00;
            m_s2 <= m_s1;
            m_s1 <= {key_dn, key_up};
            for (int k = 0; k < 2; k++) begin
                r = (syn[k] == m_last[k]) ? m_run[k] + 1 : 1;
                m_run[k]  <= r;
                m_last[k] <= syn[k];
                if (!m_low[k] && !syn[k] && r == WIN) begin
                    pulse[k] = 1'b1;
                    m_low[k] <= 1'b1;
                end else if (m_low[k] && syn[k] && r == WIN) begin
                    m_low[k] <= 1'b0;
                end
            end
            s = exp_sel;
            v = 1'b0;
            if (pulse == 2'b01) begin
                s = (exp_sel + 3'd1) % 8;
                v = 1'b1;
            end else if (pulse == 2'b10) begin
                s = (exp_sel + 3'd7) % 8;
                v = 1'b1;
            end
`ifdef KEY_SEL3_AUTO_RUN_EN
            if (pulse != 2'b00) begin
                m_auto <= 0;
            end else if (m_auto == int'(AUTO_MAX)) begin
                m_auto <= 0;
                s = (exp_sel + 3'd1) % 8;
                v = 1'b1;
            end else begin
                m_auto <= m_auto + 1;
            end
`endif
            exp_sel <= s;
            exp_vld <= v;
        end
    end

    task automatic test_reset;
        int first;
        sys_rst = 1'b1; key_up = 1'b1; key_dn = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge sys_clk);
            n_total++;
            if ({in1, in2, in3} !== 3'b000 || sel_vld !== 1'b0)
                $display("FAIL reset_idle: sel=%b vld=%b, expected sel=000 vld=0", {in1, in2, in3}, sel_vld);
            else n_pass++;
        end
        key_up = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge sys_clk);
            n_total++;
            if ({in1, in2, in3} !== 3'b000 || sel_vld !== 1'b0)
                $display("FAIL reset_held_key: sel=%b vld=%b, expected sel=000 vld=0", {in1, in2, in3}, sel_vld);
            else n_pass++;
        end
        sys_rst = 1'b0;
        first = 0;
        for (int c = 1; c <= 22; c++) begin
            if (c == 13) key_up = 1'b1;
            @(negedge sys_clk);
            if (sel_vld === 1'b1 && first == 0) first = c;
            n_total++;
            if ({in1, in2, in3} !== exp_sel || sel_vld !== exp_vld)
                $display("FAIL reset_release c=%0d: sel=%0d vld=%b, expected sel=%0d vld=%b", c, {in1, in2, in3}, sel_vld, exp_sel, exp_vld);
            else n_pass++;
        end
        n_total++;
        if (first !== LAT)
            $display("FAIL reset_window: first pulse cycle=%0d, expected %0d", first, LAT);
        else n_pass++;
    endtask

    task automatic test_clean_press;
        int first, nvld;
        sys_rst = 1'b1; key_up = 1'b1; key_dn = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        first = 0; nvld = 0;
        for (int c = 1; c <= 35; c++) begin
            key_up = (c <= 20) ? 1'b0 : 1'b1;
            @(negedge sys_clk);
            if (sel_vld === 1'b1) begin
                nvld++;
                if (first == 0) first = c;
            end
            n_total++;
            if ({in1, in2, in3} !== exp_sel || sel_vld !== exp_vld)
                $display("FAIL clean_press c=%0d: sel=%0d vld=%b, expected sel=%0d vld=%b", c, {in1, in2, in3}, sel_vld, exp_sel, exp_vld);
            else n_pass++;
            if (c == LAT + 1) begin
                n_total++;
                if (sel_vld !== 1'b0 || {in1, in2, in3} !== 3'b001)
                    $display("FAIL clean_press_after: sel=%b vld=%b, expected sel=001 vld=0", {in1, in2, in3}, sel_vld);
                else n_pass++;
            end
        end
        n_total++;
        if (first !== LAT)
            $display("FAIL clean_press_latency: first pulse cycle=%0d, expected %0d", first, LAT);
        else n_pass++;
`ifndef KEY_SEL3_AUTO_RUN_EN
        n_total++;
        if (nvld !== 1 || {in1, in2, in3} !== 3'b001)
            $display("FAIL clean_press_once: pulses=%0d sel=%b, expected 1 pulse sel=001", nvld, {in1, in2, in3});
        else n_pass++;
`endif
    endtask

    task automatic test_bounce;
        int nb, nh;
        logic [2:0] start;
        start = exp_sel;
        nb = 0; nh = 0;
        for (int c = 1; c <= 42; c++) begin
            if (c <= 20)      key_dn = (c % 4 == 0) ? 1'b1 : 1'b0;
            else if (c <= 30) key_dn = 1'b0;
            else              key_dn = 1'b1;
            @(negedge sys_clk);
            if (sel_vld === 1'b1) begin
                if (c <= 20) nb++; else nh++;
            end
            n_total++;
            if ({in1, in2, in3} !== exp_sel || sel_vld !== exp_vld)
                $display("FAIL bounce c=%0d: sel=%0d vld=%b, expected sel=%0d vld=%b", c, {in1, in2, in3}, sel_vld, exp_sel, exp_vld);
            else n_pass++;
        end
`ifndef KEY_SEL3_AUTO_RUN_EN
        n_total++;
        if (nb !== 0 || nh !== 1 || {in1, in2, in3} !== 3'((start + 3'd7) % 8))
            $display("FAIL bounce_count: bounce pulses=%0d hold pulses=%0d sel=%0d, expected 0, 1, sel=%0d", nb, nh, {in1, in2, in3}, (start + 3'd7) % 8);
        else n_pass++;
`endif
    endtask

    task automatic test_wrap;
        sys_rst = 1'b1; key_up = 1'b1; key_dn = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int p = 0; p < 9; p++) begin
            for (int c = 1; c <= 20; c++) begin
                if (p < 8) key_up = (c <= 10) ? 1'b0 : 1'b1;
                else       key_dn = (c <= 10) ? 1'b0 : 1'b1;
                @(negedge sys_clk);
                n_total++;
                if ({in1, in2, in3} !== exp_sel || sel_vld !== exp_vld)
                    $display("FAIL wrap p=%0d c=%0d: sel=%0d vld=%b, expected sel=%0d vld=%b", p, c, {in1, in2, in3}, sel_vld, exp_sel, exp_vld);
                else n_pass++;
            end
`ifndef KEY_SEL3_AUTO_RUN_EN
            n_total++;
            if ({in1, in2, in3} !== ((p < 8) ? 3'((p + 1) % 8) : 3'd7))
                $display("FAIL wrap_step p=%0d: sel=%0d, expected %0d", p, {in1, in2, in3}, (p < 8) ? (p + 1) % 8 : 7);
            else n_pass++;
`endif
        end
    endtask

    task automatic test_simultaneous;
        int both, lone, nvld;
        logic [2:0] start;
        sys_rst = 1'b1; key_up = 1'b1; key_dn = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        start = exp_sel;
        both = 0; lone = 0; nvld = 0;
        for (int c = 1; c <= 12; c++) begin
            key_up = 1'b0; key_dn = 1'b0;
            @(negedge sys_clk);
            if (dut.up_pulse === 1'b1 && dut.dn_pulse === 1'b1) both++;
            if (dut.up_pulse !== dut.dn_pulse) lone++;
            if (sel_vld === 1'b1) nvld++;
            n_total++;
            if ({in1, in2, in3} !== exp_sel || sel_vld !== exp_vld)
                $display("FAIL simultaneous c=%0d: sel=%0d vld=%b, expected sel=%0d vld=%b", c, {in1, in2, in3}, sel_vld, exp_sel, exp_vld);
            else n_pass++;
        end
        key_up = 1'b1; key_dn = 1'b1;
        repeat (10) @(negedge sys_clk);
        n_total++;
        if (both !== 1 || lone !== 0 || nvld !== 0 || {in1, in2, in3} !== start)
            $display("FAIL simultaneous_cancel: coincident=%0d lone=%0d pulses=%0d sel=%0d, expected 1, 0, 0, sel=%0d", both, lone, nvld, {in1, in2, in3}, start);
        else n_pass++;
    endtask

`ifdef KEY_SEL3_AUTO_RUN_EN
    task automatic test_auto;
        int q[$];
        sys_rst = 1'b1; key_up = 1'b1; key_dn = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge sys_clk);
            n_total++;
            if (sel_vld !== ((c % 16) == 0) || {in1, in2, in3} !== 3'(c / 16))
                $display("FAIL auto_tick c=%0d: sel=%0d vld=%b, expected sel=%0d vld=%0d", c, {in1, in2, in3}, sel_vld, c / 16, (c % 16) == 0);
            else n_pass++;
        end
        for (int c = 51; c <= 90; c++) begin
            key_up = (c <= 65) ? 1'b0 : 1'b1;
            @(negedge sys_clk);
            if (sel_vld === 1'b1) q.push_back(c);
            n_total++;
            if ({in1, in2, in3} !== exp_sel || sel_vld !== exp_vld)
                $display("FAIL auto_press c=%0d: sel=%0d vld=%b, expected sel=%0d vld=%b", c, {in1, in2, in3}, sel_vld, exp_sel, exp_vld);
            else n_pass++;
        end
        n_total++;
        if (q.size() != 3 || q[0] != 50 + LAT || q[1] - q[0] != 16 || {in1, in2, in3} !== 3'd6)
            $display("FAIL auto_restart: pulses=%0d first=%0d sel=%0d, expected 3 pulses first=%0d gap 16 sel=6", q.size(), (q.size() > 0) ? q[0] : -1, {in1, in2, in3}, 50 + LAT);
        else n_pass++;
    endtask
`else
    task automatic test_static;
        logic [2:0] start;
        start = exp_sel;
        for (int c = 1; c <= 40; c++) begin
            @(negedge sys_clk);
            n_total++;
            if ({in1, in2, in3} !== start || sel_vld !== 1'b0)
                $display("FAIL static c=%0d: sel=%0d vld=%b, expected sel=%0d vld=0", c, {in1, in2, in3}, sel_vld, start);
            else n_pass++;
        end
    endtask
`endif

    task automatic test_random;
        int hold_u, hold_d;
        hold_u = 0; hold_d = 0;
        for (int c = 1; c <= 600; c++) begin
            if (hold_u == 0) begin
                key_up = $urandom_range(0, 1);
                hold_u = $urandom_range(1, 12);
            end
            if (hold_d == 0) begin
                key_dn = $urandom_range(0, 1);
                hold_d = $urandom_range(1, 12);
            end
            hold_u--; hold_d--;
            @(negedge sys_clk);
            n_total++;
            if ({in1, in2, in3} !== exp_sel || sel_vld !== exp_vld)
                $display("FAIL random c=%0d: sel=%0d vld=%b, expected sel=%0d vld=%b", c, {in1, in2, in3}, sel_vld, exp_sel, exp_vld);
            else n_pass++;
        end
        key_up = 1'b1; key_dn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_wrap();
        test_simultaneous();
`ifdef KEY_SEL3_AUTO_RUN_EN
        test_auto();
`else
        test_static();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
